// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter merging PORTS AXI-Stream inputs onto one output.
// A grant is held from the first beat of a frame until its tlast beat is accepted.
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SEL_WIDTH  = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  input  logic [PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       output_axis_tkeep,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic                        grant_valid,
  output logic [SEL_WIDTH-1:0]        grant_index
);

  localparam logic [0:0]           ST_IDLE     = 1'b0;
  localparam logic [0:0]           ST_TRANSFER = 1'b1;
  localparam logic [SEL_WIDTH-1:0] LAST_PORT   = SEL_WIDTH'(PORTS - 1);

  logic [0:0]            r_state;
  logic [SEL_WIDTH-1:0]  r_grant_index;
  logic [SEL_WIDTH-1:0]  r_last_grant;
  logic                  r_grant_valid;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [KEEP_WIDTH-1:0] r_out_keep;
  logic                  r_out_last;
  logic                  r_out_user;

  logic                  r_tmp_valid;
  logic [DATA_WIDTH-1:0] r_tmp_data;
  logic [KEEP_WIDTH-1:0] r_tmp_keep;
  logic                  r_tmp_last;
  logic                  r_tmp_user;

  logic [PORTS-1:0]      w_req;
  logic                  w_arb_found;
  logic [SEL_WIDTH-1:0]  w_arb_index;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic                  w_sel_last;
  logic                  w_sel_user;
  logic                  w_accept;

  function automatic logic [SEL_WIDTH-1:0] wrapIndex(input logic [SEL_WIDTH-1:0] base,
                                                     input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= PORTS) sum = sum - PORTS;
    return SEL_WIDTH'(sum);
  endfunction

  assign w_req = input_axis_tvalid & port_enable;

  // Scan starts just past the previous winner so every requester is reached within PORTS frames.
  always_comb begin : arb_scan
    logic [SEL_WIDTH-1:0] cand;
    w_arb_found = 1'b0;
    w_arb_index = '0;
    cand        = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = wrapIndex(r_last_grant, k);
      if (!w_arb_found && w_req[cand]) begin
        w_arb_found = 1'b1;
        w_arb_index = cand;
      end
    end
  end

  assign w_sel_valid = input_axis_tvalid[r_grant_index];
  assign w_sel_data  = input_axis_tdata[r_grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_keep  = input_axis_tkeep[r_grant_index*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_sel_last  = input_axis_tlast[r_grant_index];
  assign w_sel_user  = input_axis_tuser[r_grant_index];

  // Ready depends only on registered state, keeping output tready off the input ready path.
  always_comb begin
    input_axis_tready = '0;
    if (r_state == ST_TRANSFER) input_axis_tready[r_grant_index] = ~r_tmp_valid;
  end

  assign w_accept = (r_state == ST_TRANSFER) && w_sel_valid && !r_tmp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_grant_index <= '0;
      r_grant_valid <= 1'b0;
      r_last_grant  <= LAST_PORT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_found) begin
            r_grant_index <= w_arb_index;
            r_grant_valid <= 1'b1;
            r_state       <= ST_TRANSFER;
          end
        end
        ST_TRANSFER: begin
          if (w_accept && w_sel_last) begin
            r_last_grant  <= r_grant_index;
            r_grant_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Temp only fills while the output register is stalled, so it always drains first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
      r_tmp_valid <= 1'b0;
      r_tmp_data  <= '0;
      r_tmp_keep  <= '0;
      r_tmp_last  <= 1'b0;
      r_tmp_user  <= 1'b0;
    end else begin
      if (!r_out_valid || output_axis_tready) begin
        if (r_tmp_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_tmp_data;
          r_out_keep  <= r_tmp_keep;
          r_out_last  <= r_tmp_last;
          r_out_user  <= r_tmp_user;
          r_tmp_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sel_data;
          r_out_keep  <= w_sel_keep;
          r_out_last  <= w_sel_last;
          r_out_user  <= w_sel_user;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_tmp_valid <= 1'b1;
        r_tmp_data  <= w_sel_data;
        r_tmp_keep  <= w_sel_keep;
        r_tmp_last  <= w_sel_last;
        r_tmp_user  <= w_sel_user;
      end
    end
  end

  assign output_axis_tvalid = r_out_valid;
  assign output_axis_tdata  = r_out_data;
  assign output_axis_tkeep  = r_out_keep;
  assign output_axis_tlast  = r_out_last;
  assign output_axis_tuser  = r_out_user;
  assign grant_valid        = r_grant_valid;
  assign grant_index        = r_grant_index;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomised bench for axis_frame_arbiter: frame-level sources, a queue-based
// output model and a rotating-priority grant model checked every cycle.
module tb_axis_frame_arbiter;

  localparam int PORTS      = 4;
  localparam int DATA_WIDTH = 64;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_WIDTH  = $clog2(PORTS);

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [PORTS*DATA_WIDTH-1:0] inTdata = '0;
  logic [PORTS*KEEP_WIDTH-1:0] inTkeep = '0;
  logic [PORTS-1:0]            inTvalid = '0;
  logic [PORTS-1:0]            inTready;
  logic [PORTS-1:0]            inTlast = '0;
  logic [PORTS-1:0]            inTuser = '0;
  logic [PORTS-1:0]            portEnable = '1;
  logic [DATA_WIDTH-1:0]       outTdata;
  logic [KEEP_WIDTH-1:0]       outTkeep;
  logic                        outTvalid;
  logic                        outTready = 1'b0;
  logic                        outTlast;
  logic                        outTuser;
  logic                        grantValid;
  logic [SEL_WIDTH-1:0]        grantIndex;

  int testCount = 0;
  int failCount = 0;

  // Sources: one pending beat per port, held until the arbiter takes it.
  logic  srcValid [PORTS];
  beat_t srcBeat  [PORTS];
  int    srcIdx   [PORTS];
  int    srcLen   [PORTS];

  // Reference: buffered beats in flight, whether a frame is owned, and by whom.
  beat_t modelQ[$];
  bit    mBusy;
  int    mGrant;
  int    mLast;

  axis_frame_arbiter #(
    .PORTS(PORTS), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(inTdata), .input_axis_tkeep(inTkeep), .input_axis_tvalid(inTvalid),
    .input_axis_tready(inTready), .input_axis_tlast(inTlast), .input_axis_tuser(inTuser),
    .port_enable(portEnable),
    .output_axis_tdata(outTdata), .output_axis_tkeep(outTkeep), .output_axis_tvalid(outTvalid),
    .output_axis_tready(outTready), .output_axis_tlast(outTlast), .output_axis_tuser(outTuser),
    .grant_valid(grantValid), .grant_index(grantIndex)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drivePorts();
    for (int p = 0; p < PORTS; p++) begin
      inTvalid[p] = srcValid[p];
      inTdata[p*DATA_WIDTH +: DATA_WIDTH] = srcBeat[p].data;
      inTkeep[p*KEEP_WIDTH +: KEEP_WIDTH] = srcBeat[p].keep;
      inTlast[p] = srcBeat[p].last;
      inTuser[p] = srcBeat[p].user;
    end
  endtask

  task automatic raiseSource(input int p);
    srcValid[p]     = 1'b1;
    srcBeat[p].data = {$urandom, $urandom};
    srcBeat[p].keep = KEEP_WIDTH'($urandom);
    srcBeat[p].user = 1'($urandom);
    srcBeat[p].last = (srcIdx[p] == srcLen[p] - 1);
  endtask

  task automatic applyStimulus(input int validPct, input int readyPct, input bit flipEnable);
    int flipPort;
    for (int p = 0; p < PORTS; p++)
      if (!srcValid[p] && ($urandom % 100) < validPct) raiseSource(p);
    if (flipEnable && ($urandom % 50) == 0) begin
      flipPort = int'($urandom % PORTS);
      portEnable[flipPort] = ~portEnable[flipPort];
    end
    outTready = (($urandom % 100) < readyPct);
    drivePorts();
  endtask

  // Advances the reference across one rising edge using the inputs now being driven.
  task automatic modelStep();
    logic [PORTS-1:0] req;
    bit popNow;
    bit acc;
    beat_t b;
    req    = inTvalid & portEnable;
    popNow = (modelQ.size() > 0) && outTready;
    acc    = 1'b0;
    if (!mBusy) begin
      if (req != 0) begin
        for (int k = 1; k <= PORTS; k++) begin
          if (req[(mLast + k) % PORTS]) begin
            mGrant = (mLast + k) % PORTS;
            break;
          end
        end
        mBusy = 1'b1;
      end
    end else if (inTvalid[mGrant] && modelQ.size() < 2) begin
      acc = 1'b1;
    end
    if (popNow) void'(modelQ.pop_front());
    if (acc) begin
      b = srcBeat[mGrant];
      modelQ.push_back(b);
      srcValid[mGrant] = 1'b0;
      if (b.last) begin
        mBusy = 1'b0;
        mLast = mGrant;
        srcIdx[mGrant] = 0;
        srcLen[mGrant] = 1 + int'($urandom % 4);
      end else begin
        srcIdx[mGrant]++;
      end
    end
  endtask

  task automatic compareAll();
    logic [PORTS-1:0] expReady;
    expReady = '0;
    if (mBusy && modelQ.size() < 2) expReady[mGrant] = 1'b1;
    checkOutput("grantValid", 64'(grantValid), 64'(mBusy));
    if (mBusy) checkOutput("grantIndex", 64'(grantIndex), 64'(mGrant));
    checkOutput("inReady", 64'(inTready), 64'(expReady));
    checkOutput("outValid", 64'(outTvalid), 64'(modelQ.size() > 0));
    if (modelQ.size() > 0) begin
      checkOutput("outData", outTdata, modelQ[0].data);
      checkOutput("outKeep", 64'(outTkeep), 64'(modelQ[0].keep));
      checkOutput("outLast", 64'(outTlast), 64'(modelQ[0].last));
      checkOutput("outUser", 64'(outTuser), 64'(modelQ[0].user));
    end
  endtask

  task automatic runCycles(input int n, input int validPct, input int readyPct, input bit flipEnable);
    for (int c = 0; c < n; c++) begin
      compareAll();
      applyStimulus(validPct, readyPct, flipEnable);
      modelStep();
      @(negedge clk);
    end
  endtask

  // Called with rst already low; checks the immediate clear, then releases on a falling edge.
  task automatic resetDut();
    #1;
    checkOutput("rstGrantValid", 64'(grantValid), 64'd0);
    checkOutput("rstGrantIndex", 64'(grantIndex), 64'd0);
    checkOutput("rstOutValid", 64'(outTvalid), 64'd0);
    checkOutput("rstOutData", outTdata, 64'd0);
    checkOutput("rstOutSide", 64'({outTkeep, outTlast, outTuser}), 64'd0);
    checkOutput("rstInReady", 64'(inTready), 64'd0);
    modelQ.delete();
    mBusy  = 1'b0;
    mGrant = 0;
    mLast  = PORTS - 1;
    for (int p = 0; p < PORTS; p++) begin
      srcValid[p] = 1'b0;
      srcIdx[p]   = 0;
      srcLen[p]   = 1 + int'($urandom % 4);
      srcBeat[p]  = '{data: '0, keep: '0, last: 1'b0, user: 1'b0};
    end
    drivePorts();
    outTready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] frameData [3];
    frameData[0] = 64'h11;
    frameData[1] = 64'h22;
    frameData[2] = 64'h33;

    #3 rst = 1'b0;
    resetDut();

    // Directed: port 2 sends a 3-beat frame into an always-ready sink.
    portEnable = '1;
    outTready  = 1'b1;
    inTvalid   = 4'b0100;
    inTdata[2*DATA_WIDTH +: DATA_WIDTH] = frameData[0];
    inTlast    = '0;
    @(negedge clk);
    checkOutput("p2Grant", 64'({grantValid, grantIndex}), 64'({1'b1, 2'd2}));
    checkOutput("p2Ready", 64'(inTready), 64'b0100);
    checkOutput("p2OutIdle", 64'(outTvalid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        @(negedge clk);
        checkOutput("p2Beat", 64'({outTvalid, outTlast}), 64'({1'b1, 1'b0}));
        checkOutput("p2Data", outTdata, frameData[i]);
        inTdata[2*DATA_WIDTH +: DATA_WIDTH] = frameData[i + 1];
        inTlast[2] = (i == 1);
      end else begin
        @(negedge clk);
        checkOutput("p2LastBeat", 64'({outTvalid, outTlast}), 64'({1'b1, 1'b1}));
        checkOutput("p2LastData", outTdata, frameData[2]);
        checkOutput("p2GrantDrop", 64'(grantValid), 64'd0);
        checkOutput("p2ReadyDrop", 64'(inTready), 64'd0);
        inTvalid = '0;
        inTlast  = '0;
      end
    end
    @(negedge clk);
    checkOutput("p2Drained", 64'(outTvalid), 64'd0);
    #2 rst = 1'b0;
    resetDut();

    $display("[TB] random phase: all ports, mostly ready sink");
    portEnable = '1;
    runCycles(800, 90, 100, 1'b0);

    $display("[TB] random phase: port 2 disabled, saturated requests");
    portEnable = 4'b1011;
    runCycles(800, 100, 70, 1'b0);

    $display("[TB] random phase: sparse valids, backpressure, enable toggling");
    portEnable = '1;
    runCycles(1500, 60, 40, 1'b1);

    // Reset mid-frame with beats buffered, then check port 0 wins over port 1.
    for (int c = 0; c < 200; c++) begin
      runCycles(1, 80, 30, 1'b0);
      if (mBusy && modelQ.size() > 0) break;
    end
    #2 rst = 1'b0;
    resetDut();
    portEnable = '1;
    outTready  = 1'b1;
    raiseSource(0);
    raiseSource(1);
    drivePorts();
    modelStep();
    @(negedge clk);
    checkOutput("rstPriority", 64'({grantValid, grantIndex}), 64'({1'b1, 2'd0}));

    $display("[TB] random phase: heavy backpressure, enable toggling");
    runCycles(1500, 85, 20, 1'b1);
    runCycles(600, 100, 100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
Frame-granular round-robin arbiter that merges PORTS AXI-Stream sources onto one AXI-Stream output, typically ahead of an axis_adapter width converter. A grant is held for a whole frame, from the first beat to the beat with tlast. It is released only after tlast is accepted. The output is registered through a two-entry skid stage, so no combinational path runs from output_axis_tready to any input tready.

Parameters:
PORTS, 4, number of input streams (2..16)
DATA_WIDTH, 64, tdata width of every input and the output
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
SEL_WIDTH, $clog2(PORTS), width of grant index

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronised externally
input_axis_tdata  in  PORTS*DATA_WIDTH  packed per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
input_axis_tkeep  in  PORTS*KEEP_WIDTH  packed per-port keep
input_axis_tvalid  in  PORTS  per-port valid
input_axis_tready  out  PORTS  per-port ready
input_axis_tlast  in  PORTS  per-port last
input_axis_tuser  in  PORTS  per-port user
port_enable  in  PORTS  1 = port may be granted
output_axis_tdata  out  DATA_WIDTH  merged data
output_axis_tkeep  out  KEEP_WIDTH  merged keep
output_axis_tvalid  out  1  merged valid
output_axis_tready  in  1  downstream ready
output_axis_tlast  out  1  merged last
output_axis_tuser  out  1  merged user
grant_valid  out  1  a frame is currently granted
grant_index  out  SEL_WIDTH  index of granted port (meaningful when grant_valid=1)

Behaviour:
- Reset values (rst=0):
  - all outputs 0; state=IDLE.
  - last_grant_reg=PORTS-1, so port 0 has first priority.
  - skid output and temp registers empty.
- Request vector: req = input_axis_tvalid & port_enable.
- State IDLE:
  - input_axis_tready all 0.
  - If req!=0, choose the first set bit of req scanning (last_grant_reg+1) mod PORTS upward with wrap.
  - Register the choice into grant_index, set grant_valid=1, go to TRANSFER.
  - Arbitration latency: 1 cycle from tvalid to grant.
- State TRANSFER:
  - input_axis_tready[grant_index] = ~temp_valid_reg; all other ports 0.
  - A beat is accepted when the granted tvalid and tready are both 1; it is pushed into the skid stage.
  - When an accepted beat has tlast=1, the transitions below occur on the next edge:
    - last_grant_reg <= grant_index;
    - grant_valid <= 0;
    - state <= IDLE.
  - There is one mandatory idle cycle between frames; back-to-back same-cycle regrant is not performed.
- Grant stability:
  - Granted tvalid dropping mid-frame holds the grant indefinitely; there is no timeout.
  - Clearing port_enable of the granted port mid-frame does not revoke the grant. It blocks only future grants.
  - tvalid or tlast on non-granted ports is ignored and never acknowledged.
- Skid output stage:
  - Holds an output register plus a temp register.
  - Push when the output register is empty or output_axis_tready=1: the beat goes to the output register; otherwise it goes to temp.
  - When output_axis_tready=1 and temp is valid, temp moves to the output register.
  - temp_valid_reg gates input ready, so at most 2 beats are buffered and none are lost or duplicated.
  - Latency is 1 cycle from accepted input beat to output_axis_tvalid.
- tkeep, tuser and tlast pass through unmodified with their beat.
- Fairness: a port with continuous req is granted within PORTS frames.
- Reset mid-frame:
  - The frame is truncated and buffered beats are discarded.
  - After reset release, arbitration restarts from port 0 priority.
- Single port (PORTS=2 with one enabled): repeated frames from the same port are granted with the 1-cycle idle gap.

Test Plan:
- Reset then port 2 sends 3-beat frame (tdata 0x11,0x22,0x33, tlast on 3rd), output_axis_tready=1 -> grant_index=2 one cycle after tvalid; output shows 0x11,0x22,0x33 consecutively, tlast only on 0x33; grant_valid drops after tlast.
- Ports 0,1,3 all assert tvalid with 2-beat frames continuously -> grant order 0,1,3,0,1,3; no beat interleaving between frames; one idle cycle between frames.
- Granted port 1 mid-frame: output_axis_tready=0 for 4 cycles -> exactly 2 beats buffered, input_axis_tready[1]=0 after second; after ready=1 all beats emerge in order, none dropped or duplicated.
- port_enable=4'b1011 with all ports requesting -> port 2 never granted; clearing port_enable[0] mid-frame while port 0 is granted -> current frame completes, port 0 is skipped afterwards.
- Granted port drops tvalid for 5 cycles mid-frame while port 3 requests -> grant stays on the original port; port 3 is granted only after tlast.
- Assert rst=0 asynchronously between edges mid-frame -> all outputs 0 immediately; after release, port 0 wins simultaneous requests from ports 0 and 1.
